// File: rtl/uc_multiciclo.sv
// Multicycle control unit: sequences the CPU datapath through
// FETCH/DECODE/EXEC/WB. It adds a program-memory handshake, a
// retired-instruction counter and a fetch watchdog.
module uc_multiciclo #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             z,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       op_alu,
  output logic [2:0]       estado,
  output logic             error,
  output logic [CNT_W-1:0] n_instr
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_WB     = 3'b100,
    S_ERROR  = 3'b111
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_opl;
  logic [WD_W-1:0]  r_wdog;
  logic [CNT_W-1:0] r_cnt;

  logic w_is_j, w_is_jz, w_is_jnz, w_is_li, w_is_alu, w_is_nop;

  // Instruction class of the latched opcode
  always_comb begin
    w_is_j   = (r_opl == 6'b001000);
    w_is_jz  = (r_opl == 6'b001001);
    w_is_jnz = (r_opl == 6'b001010);
    w_is_li  = (r_opl[5:2] == 4'b0000);
    w_is_alu = r_opl[5];
    w_is_nop = !(w_is_j || w_is_jz || w_is_jnz || w_is_li || w_is_alu);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and control word
  always_comb begin
    w_next  = r_state;
    mem_req = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    s_inc   = 1'b1;
    s_inm   = 1'b0;
    we3     = 1'b0;
    wez     = 1'b0;
    op_alu  = 3'b000;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        // a word arriving in the expiring cycle still wins over the watchdog
        if (mem_ready) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end else if (r_wdog == WD_LAST) begin
          w_next = S_ERROR;
        end
      end
      S_DECODE: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_alu) begin
          op_alu = r_opl[4:2];
          w_next = S_WB;
        end else if (w_is_li) begin
          s_inm  = 1'b1;
          w_next = S_WB;
        end else begin
          pc_we  = 1'b1;
          if (w_is_j)        s_inc = 1'b0;
          else if (w_is_jz)  s_inc = ~z;
          else if (w_is_jnz) s_inc = z;
          else               s_inc = 1'b1;
          w_next = run ? S_FETCH : S_IDLE;
        end
      end
      S_WB: begin
        pc_we = 1'b1;
        we3   = 1'b1;
        if (w_is_alu) begin
          wez    = 1'b1;
          op_alu = r_opl[4:2];
        end else begin
          s_inm = 1'b1;
        end
        w_next = run ? S_FETCH : S_IDLE;
      end
      S_ERROR: begin
        w_next = S_ERROR;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Opcode latch, loaded once the instruction register is valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_opl <= '0;
    else if (r_state == S_DECODE) r_opl <= opcode;
  end

  // Fetch watchdog: counts FETCH cycles spent waiting for memory
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_wdog <= '0;
    else if (r_state == S_FETCH && !mem_ready) r_wdog <= (r_wdog == WD_LAST) ? '0 : r_wdog + 1'b1;
    else                                       r_wdog <= '0;
  end

  // Retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_cnt <= '0;
    else if (pc_we) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign estado  = r_state;
  assign error   = (r_state == S_ERROR);
  assign n_instr = r_cnt;

  // w_is_nop is kept for readability of the class decode
  logic w_unused;
  assign w_unused = w_is_nop;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo: directed and random instruction
// sequences checked cycle by cycle against an instruction-level model.
module tb_uc_multiciclo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [5:0] opcode = '0;
  logic       z = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, ir_we, pc_we, s_inc, s_inm, we3, wez, error;
  logic [2:0] op_alu, estado;
  logic [3:0] n_instr;

  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0] model_cnt = '0;

  uc_multiciclo #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .z(z),
    .mem_ready(mem_ready), .mem_req(mem_req), .ir_we(ir_we), .pc_we(pc_we),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .op_alu(op_alu),
    .estado(estado), .error(error), .n_instr(n_instr)
  );

  always #5 clk = ~clk;

  // Expected observation: state, control word, error flag, retire count
  function automatic logic [17:0] ev(logic [2:0] st, logic mreq, logic irwe,
                                     logic pcwe, logic sinc, logic sinm,
                                     logic w3, logic wz, logic [2:0] op, logic err);
    return {st, mreq, irwe, pcwe, sinc, sinm, w3, wz, op, err, model_cnt};
  endfunction

  function automatic logic [17:0] dflt(logic [2:0] st);
    return ev(st, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [17:0] e);
    logic [17:0] o;
    o = {estado, mem_req, ir_we, pc_we, s_inc, s_inm, we3, wez, op_alu, error, n_instr};
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
    if (e[12]) model_cnt = model_cnt + 4'd1;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    run   = 1'b0;
    #1;
    model_cnt = '0;
    chk("reset_async", dflt(3'b000));
    @(negedge clk);
    #1 chk("reset_hold", dflt(3'b000));
    reset = 1'b1;
  endtask

  // n cycles parked in IDLE, then one cycle with run=1 to leave it
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      run = 1'b0;
      mem_ready = 1'($urandom);
      #1 chk("idle", dflt(3'b000));
    end
    @(negedge clk);
    run = 1'b1;
    mem_ready = 1'($urandom);
    #1 chk("idle_go", dflt(3'b000));
  endtask

  // One instruction starting in FETCH with `waits` memory wait cycles
  task automatic run_instr(input logic [5:0] opc, input logic zv, input int waits,
                           input logic run_after, input bit rst_wb);
    logic two_phase;
    logic [17:0] e;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      opcode = 6'($urandom);
      z = 1'($urandom);
      #1 chk("fetch_wait", ev(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    end
    @(negedge clk);
    mem_ready = 1'b1;
    opcode = 6'($urandom);
    #1 chk("fetch_ready", ev(3'b001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    @(negedge clk);
    mem_ready = 1'($urandom);
    opcode = opc;
    #1 chk("decode", dflt(3'b010));
    @(negedge clk);
    opcode = 6'($urandom);
    mem_ready = 1'($urandom);
    z = zv;
    run = run_after;
    two_phase = 1'b0;
    casez (opc)
      6'b001000: e = ev(3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      6'b001001: e = ev(3'b011, 1'b0, 1'b0, 1'b1, !zv, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      6'b001010: e = ev(3'b011, 1'b0, 1'b0, 1'b1, zv, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      6'b0000??: begin
        e = ev(3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        two_phase = 1'b1;
      end
      6'b1?????: begin
        e = ev(3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, opc[4:2], 1'b0);
        two_phase = 1'b1;
      end
      default:   e = ev(3'b011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    endcase
    #1 chk("exec", e);
    if (two_phase) begin
      @(negedge clk);
      z = 1'($urandom);
      mem_ready = 1'($urandom);
      if (opc[5]) e = ev(3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, opc[4:2], 1'b0);
      else        e = ev(3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      #1 chk("wb", e);
      if (rst_wb) assert_reset();
    end
  endtask

  initial begin
    logic [5:0] opc;
    logic       ra;
    @(negedge clk);
    assert_reset();
    idle(2);

    // ADD, JZ taken / not taken, LI with three wait cycles
    run_instr(6'b101000, 1'b0, 0, 1'b1, 1'b0);
    run_instr(6'b001001, 1'b1, 0, 1'b1, 1'b0);
    run_instr(6'b001001, 1'b0, 0, 1'b1, 1'b0);
    run_instr(6'b000011, 1'b0, 3, 1'b1, 1'b0);
    run_instr(6'b001000, 1'b1, 1, 1'b1, 1'b0);
    run_instr(6'b001010, 1'b1, 0, 1'b0, 1'b0);
    idle(2);
    // reset asserted during WB of an ALU op
    run_instr(6'b110100, 1'b0, 0, 1'b1, 1'b1);
    idle(1);

    // random instruction stream
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: opc = 6'b001000;
        1: opc = 6'b001001;
        2: opc = 6'b001010;
        3: opc = {4'b0000, 2'($urandom)};
        4: opc = {1'b1, 5'($urandom)};
        default: opc = 6'($urandom);
      endcase
      ra = ($urandom_range(0, 4) != 0);
      run_instr(opc, 1'($urandom), $urandom_range(0, 3), ra, 1'b0);
      if (!ra) idle($urandom_range(0, 3));
    end

    // counter wrap with 16 NOPs, run dropped in the last one
    @(negedge clk);
    assert_reset();
    idle(0);
    for (int k = 0; k < 16; k++)
      run_instr(6'b010000, 1'($urandom), 0, (k != 15), 1'b0);
    @(negedge clk);
    run = 1'b0;
    #1;
    n_assert++;
    assert (n_instr === 4'd0) else begin
      n_fail++;
      $error("FAIL wrap_count: observed %0d expected 0", n_instr);
    end
    chk("idle_after_wrap", dflt(3'b000));
    idle(0);

    // watchdog: four FETCH cycles without memory, then sticky ERROR
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1 chk("fetch_starve", ev(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = 1'b1;
      mem_ready = 1'b1;
      #1 chk("error_sticky", ev(3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1));
    end
    @(negedge clk);
    assert_reset();
    idle(0);
    run_instr(6'b100100, 1'b0, 2, 1'b0, 1'b0);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_multiciclo.md
# uc_multiciclo

Multicycle control unit that sequences the existing CPU datapath (register file, ALU, zero flag, PC mux) over several clock cycles per instruction instead of one. It adds a handshake with program memory, an instruction-retire counter and a fetch watchdog. The instruction set and the control-word meaning (`s_inc`, `s_inm`, `we3`, `wez`, `op_alu`) are unchanged from the single-cycle CPU. It replaces the single-cycle control unit in the multicycle variant of the CPU.

## Interface
- `TIMEOUT`, 16: maximum FETCH cycles without `mem_ready` before entering ERROR (≥1).
- `CNT_W`, 16: width of retired-instruction counter.

- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `run`  input  1  1 = execute; 0 = stop at next instruction boundary.
- `opcode`  input  6  instruction[15:10] from instruction register, valid from the cycle after `ir_we`.
- `z`  input  1  registered zero flag from datapath.
- `mem_ready`  input  1  program memory word valid this cycle.
- `mem_req`  output  1  fetch request to program memory.
- `ir_we`  output  1  load instruction register (1-cycle pulse).
- `pc_we`  output  1  update PC (1-cycle pulse per instruction).
- `s_inc`  output  1  PC mux: 1 = PC+1, 0 = jump target.
- `s_inm`  output  1  register write mux: 1 = immediate, 0 = ALU.
- `we3`  output  1  register file write enable.
- `wez`  output  1  zero-flag write enable.
- `op_alu`  output  3  ALU operation.
- `estado`  output  3  current state: IDLE 000, FETCH 001, DECODE 010, EXEC 011, WB 100, ERROR 111.
- `error`  output  1  fetch watchdog expired (sticky).
- `n_instr`  output  CNT_W  retired instructions, wraps modulo 2^CNT_W.

## Operation
- Opcode classes (latched opcode `opl`): 001000 J; 001001 JZ; 001010 JNZ; 0000xx LI; 1xxxxx ALU with `op_alu = opl[4:2]`. All other opcodes are NOP.
- Default output word in every state/cycle not listed below: `s_inc=1`, `s_inm=0`, `we3=0`, `wez=0`, `op_alu=000`, `pc_we=0`, `ir_we=0`, `mem_req=0`.
- IDLE: if `run` = 1, go to FETCH; otherwise stay in IDLE.
- FETCH: `mem_req=1`; the watchdog counter increments each cycle.
  - If `mem_ready` = 1: `ir_we=1`, clear the watchdog, go to DECODE.
  - If the watchdog reaches `TIMEOUT` without `mem_ready`: go to ERROR. `mem_ready` in the expiring cycle still wins.
- DECODE: latch `opcode` into `opl`; go to EXEC.
- EXEC:
  - J: `pc_we=1`, `s_inc=0`.
  - JZ: `pc_we=1`, `s_inc = ~z`.
  - JNZ: `pc_we=1`, `s_inc = z`.
  - NOP: `pc_we=1`, `s_inc=1`.
  - For J/JZ/JNZ/NOP, the instruction retires here and the next state is FETCH if `run`, else IDLE.
  - ALU: `op_alu = opl[4:2]`, go to WB.
  - LI: `s_inm=1`, go to WB.
- WB: `pc_we=1`, `s_inc=1`, instruction retires, next state is FETCH if `run`, else IDLE.
  - ALU: `we3=1`, `wez=1`, `op_alu` held from EXEC.
  - LI: `we3=1`, `s_inm=1`.
- Retire: `n_instr` increments by 1 in the cycle `pc_we=1`.
- ERROR: all outputs at default, `error=1`. Exited only by `reset`; `run` is ignored.
- `z` is sampled combinationally in EXEC only. The flag changes only in WB of ALU instructions, so it is stable during EXEC.

## Timing
- Reset (async, asserted low): state IDLE, `opl=0`, watchdog 0, `n_instr=0`, `error=0`, all control outputs at default. This takes effect immediately, including mid-instruction; no partial write completes after assertion.
- Reset release: first transition out of IDLE occurs on the first rising edge with `reset`=1 and `run`=1.
- Latency with zero memory wait (FETCH = 1 cycle):
  - J, JZ, JNZ, NOP: 3 cycles.
  - LI, ALU: 4 cycles.
  - Each cycle of `mem_ready`=0 adds one FETCH cycle.
- `run` deasserted mid-instruction: the instruction completes, then the unit goes to IDLE. `run`=1 in IDLE starts FETCH on the next edge.
- `mem_req` stays high continuously while in FETCH, which makes it a level handshake. `mem_ready` outside FETCH is ignored.
- Exactly one `ir_we` and one `pc_we` pulse per instruction.
- `n_instr` at 2^CNT_W−1 wraps to 0 on the next retire.

## Test plan
- Reset mid-WB of ALU op (`we3`=1) -> outputs default and `estado`=000 immediately; `n_instr`=0.
- `run`=1, `mem_ready`=1, opcode 101000 (ADD) -> `estado` 001,010,011,100. WB: `we3`=1, `wez`=1, `op_alu`=010, `pc_we`=1. `n_instr`=1 after 4 cycles.
- JZ (001001) with `z`=1, then with `z`=0 -> EXEC `pc_we`=1 with `s_inc`=0, then `s_inc`=1; 3 cycles each; no `we3`.
- LI (000011) with `mem_ready` low 3 cycles -> FETCH lasts 4 cycles. `ir_we` pulses once. WB: `s_inm`=1, `we3`=1, `wez`=0. Total 7 cycles.
- `TIMEOUT`=4, `mem_ready` held 0 -> ERROR after 4 FETCH cycles, `error`=1, `estado`=111. Stays there with `run`=1 and `mem_ready`=1 until reset.
- `CNT_W`=4, 16 NOPs (opcode 111111 is ALU, so use 010000) -> `n_instr` wraps to 0. `run` dropped during the 16th -> IDLE after its EXEC.
